// File: rtl/ycbcr_skin_detect.sv
// Cb/Cr window skin classifier: 2-stage mask pipeline plus per-frame skin count and bounding box.
// Define SKIN_BBOX_EN to build the bounding-box tracker; without it bbox_* are tied to zero.
`timescale 1ns/1ps
module ycbcr_skin_detect #(
  parameter int unsigned X_BITS   = 11,
  parameter int unsigned Y_BITS   = 11,
  parameter int unsigned CNT_BITS = 22,
  parameter logic [23:0] FG_RGB   = 24'hFFFFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                EN,
  input  logic                pre_vs,
  input  logic                pre_de,
  input  logic [7:0]          pre_y,
  input  logic [7:0]          pre_cb,
  input  logic [7:0]          pre_cr,
  input  logic [7:0]          cb_min,
  input  logic [7:0]          cb_max,
  input  logic [7:0]          cr_min,
  input  logic [7:0]          cr_max,
  output logic                post_vs,
  output logic                post_de,
  output logic [23:0]         post_data,
  output logic                frame_done,
  output logic [CNT_BITS-1:0] skin_cnt,
  output logic                bbox_valid,
  output logic [X_BITS-1:0]   bbox_x0,
  output logic [X_BITS-1:0]   bbox_x1,
  output logic [Y_BITS-1:0]   bbox_y0,
  output logic [Y_BITS-1:0]   bbox_y1
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_LATCH, ST_BLANK} state_t;

  state_t              state_q, state_d;
  logic                in_win;
  logic                hit1_q, hit1_d;
  logic                de1_q, vs1_q, de2_q, vs2_q;
  logic [23:0]         data2_q, data2_d;
  logic [CNT_BITS-1:0] skin_acc_q, skin_acc_d;
  logic [CNT_BITS-1:0] skin_cnt_q, skin_cnt_d;
  logic                frame_done_q, frame_done_d;
  logic                vs_fall, vs_rise;
  logic                acc_clr, acc_en;

`ifdef SKIN_BBOX_EN
  logic              de_prev_q;
  logic [X_BITS-1:0] col_q, col_d, col1_q;
  logic [Y_BITS-1:0] row_q, row_d, row1_q;
  logic [X_BITS-1:0] x_min_q, x_min_d, x_max_q, x_max_d;
  logic [Y_BITS-1:0] y_min_q, y_min_d, y_max_q, y_max_d;
  logic              any_hit_q, any_hit_d;
  logic              bbox_valid_q, bbox_valid_d;
  logic [X_BITS-1:0] bbox_x0_q, bbox_x0_d, bbox_x1_q, bbox_x1_d;
  logic [Y_BITS-1:0] bbox_y0_q, bbox_y0_d, bbox_y1_q, bbox_y1_d;
`endif

  // An inverted window (min > max) can never satisfy both bounds, so no special case is needed.
  always_comb begin
    in_win  = (pre_cb >= cb_min) && (pre_cb <= cb_max) &&
              (pre_cr >= cr_min) && (pre_cr <= cr_max);
    hit1_d  = pre_de & ~pre_vs & in_win;
    data2_d = hit1_q ? FG_RGB : 24'h000000;
  end

`ifdef SKIN_BBOX_EN
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pre_vs) begin
      col_d = '0;
      row_d = '0;
    end else if (pre_de) begin
      col_d = col_q + 1'b1;
    end else if (de_prev_q) begin
      col_d = '0;
      row_d = row_q + 1'b1;
    end
  end
`endif

  // Frame boundaries are taken from the stage-1 vs so the final pixel's hit lands before LATCH.
  assign vs_fall = vs2_q & ~vs1_q;
  assign vs_rise = ~vs2_q & vs1_q;

  always_comb begin
    state_d      = state_q;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;
    frame_done_d = 1'b0;
    skin_cnt_d   = skin_cnt_q;
`ifdef SKIN_BBOX_EN
    bbox_valid_d = bbox_valid_q;
    bbox_x0_d    = bbox_x0_q;
    bbox_x1_d    = bbox_x1_q;
    bbox_y0_d    = bbox_y0_q;
    bbox_y1_d    = bbox_y1_q;
`endif
    if (!EN) begin
      state_d = ST_IDLE;
      acc_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_BLANK: begin
          acc_clr = 1'b1;
          if (vs_fall) begin
            state_d = ST_ACCUM;
            acc_en  = 1'b1;
          end
        end
        ST_ACCUM: begin
          acc_en = 1'b1;
          if (vs_rise) state_d = ST_LATCH;
        end
        ST_LATCH: begin
          skin_cnt_d   = skin_acc_q;
          frame_done_d = 1'b1;
          state_d      = ST_BLANK;
`ifdef SKIN_BBOX_EN
          bbox_valid_d = any_hit_q;
          bbox_x0_d    = any_hit_q ? x_min_q : '0;
          bbox_x1_d    = any_hit_q ? x_max_q : '0;
          bbox_y0_d    = any_hit_q ? y_min_q : '0;
          bbox_y1_d    = any_hit_q ? y_max_q : '0;
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Clearing and accumulating in the same cycle starts a fresh frame with the current hit.
  always_comb begin
    skin_acc_d = acc_clr ? '0 : skin_acc_q;
`ifdef SKIN_BBOX_EN
    x_min_d   = acc_clr ? '1 : x_min_q;
    x_max_d   = acc_clr ? '0 : x_max_q;
    y_min_d   = acc_clr ? '1 : y_min_q;
    y_max_d   = acc_clr ? '0 : y_max_q;
    any_hit_d = acc_clr ? 1'b0 : any_hit_q;
`endif
    if (acc_en && hit1_q) begin
      if (skin_acc_d != {CNT_BITS{1'b1}}) skin_acc_d = skin_acc_d + 1'b1;
`ifdef SKIN_BBOX_EN
      any_hit_d = 1'b1;
      if (col1_q < x_min_d) x_min_d = col1_q;
      if (col1_q > x_max_d) x_max_d = col1_q;
      if (row1_q < y_min_d) y_min_d = row1_q;
      if (row1_q > y_max_d) y_max_d = row1_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hit1_q       <= 1'b0;
      de1_q        <= 1'b0;
      vs1_q        <= 1'b0;
      de2_q        <= 1'b0;
      vs2_q        <= 1'b0;
      data2_q      <= '0;
      skin_acc_q   <= '0;
      skin_cnt_q   <= '0;
      frame_done_q <= 1'b0;
`ifdef SKIN_BBOX_EN
      de_prev_q    <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      col1_q       <= '0;
      row1_q       <= '0;
      x_min_q      <= '1;
      x_max_q      <= '0;
      y_min_q      <= '1;
      y_max_q      <= '0;
      any_hit_q    <= 1'b0;
      bbox_valid_q <= 1'b0;
      bbox_x0_q    <= '0;
      bbox_x1_q    <= '0;
      bbox_y0_q    <= '0;
      bbox_y1_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hit1_q       <= hit1_d;
      de1_q        <= pre_de;
      vs1_q        <= pre_vs;
      de2_q        <= de1_q;
      vs2_q        <= vs1_q;
      data2_q      <= data2_d;
      skin_acc_q   <= skin_acc_d;
      skin_cnt_q   <= skin_cnt_d;
      frame_done_q <= frame_done_d;
`ifdef SKIN_BBOX_EN
      de_prev_q    <= pre_de;
      col_q        <= col_d;
      row_q        <= row_d;
      col1_q       <= pre_vs ? '0 : col_q;
      row1_q       <= pre_vs ? '0 : row_q;
      x_min_q      <= x_min_d;
      x_max_q      <= x_max_d;
      y_min_q      <= y_min_d;
      y_max_q      <= y_max_d;
      any_hit_q    <= any_hit_d;
      bbox_valid_q <= bbox_valid_d;
      bbox_x0_q    <= bbox_x0_d;
      bbox_x1_q    <= bbox_x1_d;
      bbox_y0_q    <= bbox_y0_d;
      bbox_y1_q    <= bbox_y1_d;
`endif
    end
  end

  assign post_vs    = EN ? vs2_q   : pre_vs;
  assign post_de    = EN ? de2_q   : pre_de;
  assign post_data  = EN ? data2_q : {pre_y, pre_cb, pre_cr};
  assign frame_done = frame_done_q;
  assign skin_cnt   = skin_cnt_q;

`ifdef SKIN_BBOX_EN
  assign bbox_valid = bbox_valid_q;
  assign bbox_x0    = bbox_x0_q;
  assign bbox_x1    = bbox_x1_q;
  assign bbox_y0    = bbox_y0_q;
  assign bbox_y1    = bbox_y1_q;
`else
  assign bbox_valid = 1'b0;
  assign bbox_x0    = '0;
  assign bbox_x1    = '0;
  assign bbox_y0    = '0;
  assign bbox_y1    = '0;
`endif

endmodule

// File: tb/tb_ycbcr_skin_detect.sv
// Scoreboard bench for ycbcr_skin_detect: mask pipeline, bypass, frame statistics and saturation.
`timescale 1ns/1ps
module tb_ycbcr_skin_detect;

  localparam logic [23:0] FG = 24'hFFFFFF;
`ifdef SKIN_BBOX_EN
  localparam bit BBOX_ON = 1'b1;
`else
  localparam bit BBOX_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EN;
  logic        pre_vs, pre_de;
  logic [7:0]  pre_y, pre_cb, pre_cr;
  logic [7:0]  cb_min, cb_max, cr_min, cr_max;
  logic        post_vs, post_de, frame_done, bbox_valid;
  logic [23:0] post_data;
  logic [21:0] skin_cnt;
  logic [10:0] bbox_x0, bbox_x1, bbox_y0, bbox_y1;
  logic        s_vs, s_de, s_fd, s_bv;
  logic [23:0] s_data;
  logic [3:0]  s_cnt;
  logic [10:0] s_x0, s_x1, s_y0, s_y1;

  always #5 clk = ~clk;

  ycbcr_skin_detect dut (
    .clk(clk), .rst_n(rst_n), .EN(EN), .pre_vs(pre_vs), .pre_de(pre_de),
    .pre_y(pre_y), .pre_cb(pre_cb), .pre_cr(pre_cr),
    .cb_min(cb_min), .cb_max(cb_max), .cr_min(cr_min), .cr_max(cr_max),
    .post_vs(post_vs), .post_de(post_de), .post_data(post_data),
    .frame_done(frame_done), .skin_cnt(skin_cnt), .bbox_valid(bbox_valid),
    .bbox_x0(bbox_x0), .bbox_x1(bbox_x1), .bbox_y0(bbox_y0), .bbox_y1(bbox_y1)
  );

  ycbcr_skin_detect #(.CNT_BITS(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .EN(EN), .pre_vs(pre_vs), .pre_de(pre_de),
    .pre_y(pre_y), .pre_cb(pre_cb), .pre_cr(pre_cr),
    .cb_min(cb_min), .cb_max(cb_max), .cr_min(cr_min), .cr_max(cr_max),
    .post_vs(s_vs), .post_de(s_de), .post_data(s_data),
    .frame_done(s_fd), .skin_cnt(s_cnt), .bbox_valid(s_bv),
    .bbox_x0(s_x0), .bbox_x1(s_x1), .bbox_y0(s_y0), .bbox_y1(s_y1)
  );

  typedef struct {
    logic        vs;
    logic        de;
    logic [23:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   fd_count = 0;
  int   lat_cnt = 0, lat_bv = 0, lat_x0 = 0, lat_x1 = 0, lat_y0 = 0, lat_y1 = 0;
  logic [7:0] px_cb[0:7][0:3];
  logic [7:0] px_cr[0:7][0:3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit win(input logic [7:0] cb, input logic [7:0] cr);
    return (cb >= cb_min) && (cb <= cb_max) && (cr >= cr_min) && (cr <= cr_max);
  endfunction

  task automatic cyc(input logic vs, input logic de, input logic [7:0] y,
                     input logic [7:0] cb, input logic [7:0] cr);
    exp_t e;
    @(posedge clk);
    #1;
    pre_vs = vs; pre_de = de; pre_y = y; pre_cb = cb; pre_cr = cr;
    e.vs   = vs;
    e.de   = de;
    e.data = (!vs && de && win(cb, cr)) ? FG : 24'h0;
    sb_q.push_back(e);
  endtask

  // Outputs at each falling edge reflect the inputs driven two cycles earlier.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out", {post_vs, post_de, post_data, frame_done, skin_cnt, bbox_valid}, 64'h0);
      sb_q.delete();
    end else begin
      if (!EN)
        chk("bypass", {post_vs, post_de, post_data}, {pre_vs, pre_de, pre_y, pre_cb, pre_cr});
      if (sb_q.size() >= 3) begin
        mon_e = sb_q.pop_front();
        if (EN) chk("pipe", {post_vs, post_de, post_data}, {mon_e.vs, mon_e.de, mon_e.data});
      end
      if (frame_done) fd_count++;
    end
  end

  task automatic check_latched();
    chk("skin_cnt", skin_cnt, lat_cnt);
    chk("cnt4", s_cnt, (lat_cnt > 15) ? 15 : lat_cnt);
    chk("bbox_valid", bbox_valid, BBOX_ON ? lat_bv : 0);
    chk("bbox_x0", bbox_x0, BBOX_ON ? lat_x0 : 0);
    chk("bbox_x1", bbox_x1, BBOX_ON ? lat_x1 : 0);
    chk("bbox_y0", bbox_y0, BBOX_ON ? lat_y0 : 0);
    chk("bbox_y1", bbox_y1, BBOX_ON ? lat_y1 : 0);
  endtask

  task automatic fill(input logic [7:0] cb, input logic [7:0] cr);
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 4; y++) begin
        px_cb[x][y] = cb;
        px_cr[x][y] = cr;
      end
  endtask

  task automatic frame(input int w, input int h, input int tog_row, input bit exp_pulse);
    int cnt = 0, x0 = 9999, x1 = 0, y0 = 9999, y1 = 0;
    int fd0;
    fd0 = fd_count;
    repeat (4) cyc(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int r = 0; r < h; r++) begin
      if (r == tog_row) EN = ~EN;
      repeat (2) cyc(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      for (int c = 0; c < w; c++) begin
        cyc(1'b0, 1'b1, 8'(c * 16 + r), px_cb[c][r], px_cr[c][r]);
        if (win(px_cb[c][r], px_cr[c][r])) begin
          cnt++;
          if (c < x0) x0 = c;
          if (c > x1) x1 = c;
          if (r < y0) y0 = r;
          if (r > y1) y1 = r;
        end
      end
      repeat (2) cyc(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    end
    repeat (10) cyc(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    chk("fd_pulses", fd_count - fd0, exp_pulse);
    if (exp_pulse) begin
      lat_cnt = cnt;
      lat_bv  = (cnt > 0);
      lat_x0  = (cnt > 0) ? x0 : 0;
      lat_x1  = (cnt > 0) ? x1 : 0;
      lat_y0  = (cnt > 0) ? y0 : 0;
      lat_y1  = (cnt > 0) ? y1 : 0;
    end
    check_latched();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; EN = 1'b1;
    pre_vs = 1'b0; pre_de = 1'b0; pre_y = '0; pre_cb = '0; pre_cr = '0;
    cb_min = 8'd77; cb_max = 8'd127; cr_min = 8'd133; cr_max = 8'd173;
    #2 rst_n = 1'b0;

    // Reset in the middle of an active line; the partial frame must not produce stats.
    repeat (5) cyc(1'b0, 1'b1, 8'd90, 8'd100, 8'd150);
    rst_n = 1'b1;
    repeat (6) cyc(1'b0, 1'b1, 8'd90, 8'd100, 8'd150);
    repeat (2) cyc(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    repeat (8) cyc(1'b0, 1'b1, 8'd90, 8'd100, 8'd150);
    repeat (2) cyc(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    repeat (10) cyc(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    chk("rst_no_fd", fd_count, 0);
    check_latched();

    // Window boundary pixels on one short line.
    fill(8'd50, 8'd50);
    px_cb[0][0] = 8'd100; px_cr[0][0] = 8'd150;
    px_cb[1][0] = 8'd76;  px_cr[1][0] = 8'd150;
    px_cb[2][0] = 8'd127; px_cr[2][0] = 8'd173;
    px_cb[3][0] = 8'd128; px_cr[3][0] = 8'd150;
    frame(4, 1, -1, 1'b1);

    // Sparse skin in an 8x4 frame.
    fill(8'd50, 8'd50);
    px_cb[2][1] = 8'd100; px_cr[2][1] = 8'd150;
    px_cb[5][1] = 8'd100; px_cr[5][1] = 8'd150;
    px_cb[3][3] = 8'd100; px_cr[3][3] = 8'd150;
    frame(8, 4, -1, 1'b1);

    // No skin, then an inverted window over skin-coloured pixels.
    fill(8'd50, 8'd50);
    frame(8, 4, -1, 1'b1);
    cb_min = 8'd200; cb_max = 8'd100;
    fill(8'd100, 8'd150);
    frame(8, 4, -1, 1'b1);
    cb_min = 8'd77; cb_max = 8'd127;

    // Restore known stats, then EN off mid-frame, fully off, and on mid-frame.
    fill(8'd50, 8'd50);
    px_cb[6][2] = 8'd90; px_cr[6][2] = 8'd140;
    px_cb[1][0] = 8'd120; px_cr[1][0] = 8'd170;
    frame(8, 4, -1, 1'b1);
    fill(8'd100, 8'd150);
    frame(8, 4, 2, 1'b0);
    frame(8, 4, -1, 1'b0);
    frame(8, 4, 2, 1'b0);
    chk("en_restored", EN, 1'b1);
    fill(8'd50, 8'd50);
    px_cb[4][2] = 8'd80; px_cr[4][2] = 8'd135;
    frame(8, 4, -1, 1'b1);

    // All-skin frame: 32 hits, saturates the 4-bit counter instance at 15.
    fill(8'd100, 8'd150);
    frame(8, 4, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
